// File: rtl/ascon_stream_sequencer.sv
// ascon_stream_sequencer
//   Front-end between a bus/DMA block stream and an ASCON-128/128a core.
//   Buffers padded AD/PT blocks in a FIFO, sequences the core handshake for
//   one session (start, AD phase, PT phase, finalisation), returns the
//   ciphertext through a backpressured output register, captures the tag,
//   and aborts a session that waits too long on the core.
//
// Ports
//   clock_i, reset_i          clock, synchronous active-high reset
//   cmd_*                     session command (AD/PT block counts), cmd_ready_o in IDLE only
//   in_valid_i/in_ready_o     input block stream into the FIFO, in_data_i block
//   fifo_level_o              FIFO occupancy
//   core_start_o              one-cycle start pulse to the core
//   core_data_valid_o         one-cycle block issue, with core_last_o / core_data_o
//   core_ready_i              core can accept a block
//   core_cipher_valid_i/_i    ciphertext returned by the core
//   core_end_i, core_tag_i    finalisation done and tag
//   out_valid_o/out_ready_i   ciphertext output register, out_data_o / out_last_o
//   tag_o                     captured tag
//   done_o, err_o             one-cycle completion / error pulses
//   busy_o                    session in progress
module ascon_stream_sequencer #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [CNT_W-1:0]                cmd_n_ad_i,
  input  logic [CNT_W-1:0]                cmd_n_pt_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [DATA_W-1:0]               in_data_i,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic                            core_start_o,
  output logic                            core_data_valid_o,
  output logic                            core_last_o,
  output logic [DATA_W-1:0]               core_data_o,
  input  logic                            core_ready_i,
  input  logic                            core_cipher_valid_i,
  input  logic [DATA_W-1:0]               core_cipher_i,
  input  logic                            core_end_i,
  input  logic [127:0]                    core_tag_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [DATA_W-1:0]               out_data_o,
  output logic                            out_last_o,
  output logic [127:0]                    tag_o,
  output logic                            done_o,
  output logic                            err_o,
  output logic                            busy_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_INIT_WAIT,
    S_AD,
    S_PT,
    S_GAP,
    S_CT_WAIT,
    S_TAG_WAIT
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e              state_q;
  logic [CNT_W-1:0]    n_ad_q, n_pt_q;
  logic [CNT_W-1:0]    ad_cnt_q, pt_cnt_q;
  logic [WD_W-1:0]     wd_q;

  logic                core_start_q, core_dv_q, core_last_q;
  logic [DATA_W-1:0]   core_data_q;
  logic                out_valid_q, out_last_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [127:0]        tag_q;
  logic                done_q, err_q;

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic              ad_issue, pt_issue;
  logic              wd_count, timeout;
  logic [DATA_W-1:0] fifo_head;

  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    fifo_head  = mem_q[rd_ptr_q];

    ad_issue = (state_q == S_AD) && !fifo_empty && core_ready_i;
    // A PT block is held back while ciphertext is still pending in the
    // output register, so the register can never be overwritten.
    pt_issue = (state_q == S_PT) && !fifo_empty && core_ready_i && !out_valid_q;

    push = in_valid_i && !fifo_full;
    pop  = ad_issue || pt_issue;

    wd_count = (state_q == S_INIT_WAIT) || (state_q == S_CT_WAIT) ||
               (state_q == S_TAG_WAIT) ||
               (((state_q == S_AD) || (state_q == S_PT)) && fifo_empty);
    timeout  = wd_count && (wd_q == WD_W'(TIMEOUT - 1));
  end

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || timeout) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Session FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      n_ad_q       <= '0;
      n_pt_q       <= '0;
      ad_cnt_q     <= '0;
      pt_cnt_q     <= '0;
      wd_q         <= '0;
      core_start_q <= 1'b0;
      core_dv_q    <= 1'b0;
      core_last_q  <= 1'b0;
      core_data_q  <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      tag_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      core_dv_q    <= 1'b0;
      core_last_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;

      // Free-running watchdog; every state transition below clears it.
      wd_q <= wd_count ? wd_q + 1'b1 : '0;

      if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
      end

      if (timeout) begin
        err_q       <= 1'b1;
        state_q     <= S_IDLE;
        ad_cnt_q    <= '0;
        pt_cnt_q    <= '0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        wd_q        <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (cmd_valid_i) begin
              n_ad_q   <= cmd_n_ad_i;
              n_pt_q   <= cmd_n_pt_i;
              ad_cnt_q <= '0;
              pt_cnt_q <= '0;
              if (cmd_n_pt_i == '0) begin
                err_q <= 1'b1;
              end else begin
                // Start pulse is raised on the accept edge so it appears
                // exactly one cycle after the command is taken.
                core_start_q <= 1'b1;
                tag_q        <= '0;
                state_q      <= S_START;
                wd_q         <= '0;
              end
            end
          end

          S_START: begin
            state_q <= S_INIT_WAIT;
            wd_q    <= '0;
          end

          S_INIT_WAIT: begin
            if (core_ready_i) begin
              state_q <= (n_ad_q != '0) ? S_AD : S_PT;
              wd_q    <= '0;
            end
          end

          S_AD: begin
            if (ad_issue) begin
              core_dv_q   <= 1'b1;
              core_data_q <= fifo_head;
              core_last_q <= (ad_cnt_q == n_ad_q - 1'b1);
              ad_cnt_q    <= ad_cnt_q + 1'b1;
              state_q     <= S_GAP;
              wd_q        <= '0;
            end
          end

          S_GAP: begin
            state_q <= (ad_cnt_q < n_ad_q) ? S_AD : S_PT;
            wd_q    <= '0;
          end

          S_PT: begin
            if (pt_issue) begin
              core_dv_q   <= 1'b1;
              core_data_q <= fifo_head;
              core_last_q <= (pt_cnt_q == n_pt_q - 1'b1);
              pt_cnt_q    <= pt_cnt_q + 1'b1;
              state_q     <= S_CT_WAIT;
              wd_q        <= '0;
            end
          end

          S_CT_WAIT: begin
            if (core_cipher_valid_i) begin
              out_data_q  <= core_cipher_i;
              out_valid_q <= 1'b1;
              out_last_q  <= (pt_cnt_q == n_pt_q);
              state_q     <= (pt_cnt_q < n_pt_q) ? S_PT : S_TAG_WAIT;
              wd_q        <= '0;
            end
          end

          S_TAG_WAIT: begin
            if (core_end_i) begin
              tag_q   <= core_tag_i;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
              wd_q    <= '0;
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready_o       = (state_q == S_IDLE);
  assign busy_o            = (state_q != S_IDLE);
  assign in_ready_o        = !fifo_full;
  assign fifo_level_o      = level_q;
  assign core_start_o      = core_start_q;
  assign core_data_valid_o = core_dv_q;
  assign core_last_o       = core_last_q;
  assign core_data_o       = core_data_q;
  assign out_valid_o       = out_valid_q;
  assign out_data_o        = out_data_q;
  assign out_last_o        = out_last_q;
  assign tag_o             = tag_q;
  assign done_o            = done_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_ascon_stream_sequencer.sv
// Testbench for ascon_stream_sequencer: table-driven sessions, randomized
// sessions and hand-written corner sequences against a block-level model.
module tb_ascon_stream_sequencer;

  localparam int          DW  = 64;
  localparam int          CW  = 8;
  localparam int          TO  = 1024;
  localparam logic [63:0] KEY = 64'hA5A5A5A5A5A5A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           cmd_valid_i, cmd_ready_o;
  logic [CW-1:0]  cmd_n_ad_i, cmd_n_pt_i;
  logic           in_valid_i, in_ready_o;
  logic [DW-1:0]  in_data_i;
  logic [3:0]     fifo_level_o;
  logic           core_start_o, core_data_valid_o, core_last_o;
  logic [DW-1:0]  core_data_o;
  logic           core_ready_i, core_cipher_valid_i, core_end_i;
  logic [DW-1:0]  core_cipher_i;
  logic [127:0]   core_tag_i;
  logic           out_valid_o, out_ready_i, out_last_o;
  logic [DW-1:0]  out_data_o;
  logic [127:0]   tag_o;
  logic           done_o, err_o, busy_o;

  ascon_stream_sequencer #(.DATA_W(DW), .FIFO_DEPTH(8), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clock_i(clk), .reset_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_n_ad_i(cmd_n_ad_i), .cmd_n_pt_i(cmd_n_pt_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .fifo_level_o(fifo_level_o),
    .core_start_o(core_start_o), .core_data_valid_o(core_data_valid_o),
    .core_last_o(core_last_o), .core_data_o(core_data_o),
    .core_ready_i(core_ready_i), .core_cipher_valid_i(core_cipher_valid_i),
    .core_cipher_i(core_cipher_i), .core_end_i(core_end_i), .core_tag_i(core_tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o),
    .tag_o(tag_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
  );

  int tests = 0;
  int fails = 0;

  // environment configuration
  bit ready_allow = 1'b1, rand_ready = 1'b0, rand_in = 1'b0, end_en = 1'b1;
  int bp_mode = 0;   // 0 always ready, 1 random, 2 hold low 20 cycles at first ciphertext
  int cur_n_ad = 0, cur_n_pt = 0;

  // feeder and scoreboards
  logic [63:0] feed_q[$];
  bit          feed_acc = 1'b0;
  logic [63:0] iss_d[$];
  bit          iss_l[$];
  logic [63:0] out_d[$];
  bit          out_l[$];
  int          done_cnt = 0, err_cnt = 0, start_cnt = 0, viol = 0, cyc = 0;
  int          ov_rise_cyc = 0, err_cyc = 0;
  bit          cmd_ready_low = 1'b0;
  logic [127:0] tag_seen = '0;

  // core model state
  int          init_cnt = 0, iss_idx = 0, end_due = -1;
  bit          init_done = 1'b0;
  int          pend_due[$];
  logic [63:0] pend_dat[$];
  logic [63:0] tag_acc = '0;
  bit          prev_ov = 1'b0, prev_rdy = 1'b0, stall_started = 1'b0;
  int          stall_left = 0;
  logic [63:0] prev_od = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle environment: input feeder, core model, output consumer, monitor.
  initial begin
    in_valid_i = 0; in_data_i = '0; core_ready_i = 0; core_cipher_valid_i = 0;
    core_cipher_i = '0; core_end_i = 0; core_tag_i = '0; out_ready_i = 1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        feed_q.delete(); feed_acc = 0; in_valid_i = 0;
        pend_due.delete(); pend_dat.delete(); end_due = -1; init_cnt = 0; init_done = 0;
        core_ready_i = 0; core_cipher_valid_i = 0; core_end_i = 0;
        prev_ov = 0; prev_rdy = 0;
        continue;
      end
      // feeder
      if (feed_acc) void'(feed_q.pop_front());
      in_valid_i = (feed_q.size() > 0) && (!rand_in || $urandom_range(3) != 0);
      in_data_i  = (feed_q.size() > 0) ? feed_q[0] : '0;
      feed_acc   = in_valid_i && in_ready_o;
      // core model
      core_cipher_valid_i = 0;
      core_end_i = 0;
      if (core_start_o) begin
        start_cnt++; init_cnt = 12; init_done = 0; iss_idx = 0; tag_acc = '0;
      end else if (init_cnt > 0) begin
        init_cnt--;
        if (init_cnt == 0) init_done = 1;
      end
      core_ready_i = init_done && ready_allow && (!rand_ready || $urandom_range(1) == 1);
      if (core_data_valid_o) begin
        if (iss_idx >= cur_n_ad && prev_ov) viol++;
        iss_d.push_back(core_data_o);
        iss_l.push_back(core_last_o);
        tag_acc ^= core_data_o;
        if (iss_idx >= cur_n_ad) begin
          pend_due.push_back(cyc + 6);
          pend_dat.push_back(core_data_o ^ KEY);
          if (iss_idx == cur_n_ad + cur_n_pt - 1 && end_en) end_due = cyc + 10;
        end
        iss_idx++;
      end
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        core_cipher_valid_i = 1;
        core_cipher_i = pend_dat.pop_front();
        void'(pend_due.pop_front());
      end
      if (end_due == cyc) begin
        core_end_i = 1;
        core_tag_i = {tag_acc, ~tag_acc};
      end
      // monitor
      if (done_o) begin done_cnt++; tag_seen = tag_o; end
      if (err_o) begin err_cnt++; err_cyc = cyc; end
      if (!cmd_ready_o) cmd_ready_low = 1;
      if (out_valid_o && !prev_ov) ov_rise_cyc = cyc;
      if (prev_ov && !prev_rdy && (!out_valid_o || out_data_o !== prev_od)) viol++;
      // consumer
      case (bp_mode)
        1: out_ready_i = ($urandom_range(1) == 1);
        2: begin
          if (out_valid_o && !stall_started) begin stall_started = 1; stall_left = 20; end
          if (stall_left > 0) begin out_ready_i = 0; stall_left--; end
          else out_ready_i = 1;
        end
        default: out_ready_i = 1;
      endcase
      if (out_valid_o && out_ready_i) begin
        out_d.push_back(out_data_o);
        out_l.push_back(out_last_o);
      end
      prev_ov = out_valid_o; prev_rdy = out_ready_i; prev_od = out_data_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_sb();
    iss_d.delete(); iss_l.delete(); out_d.delete(); out_l.delete();
    done_cnt = 0; err_cnt = 0; start_cnt = 0; viol = 0;
    cmd_ready_low = 0; stall_started = 0; stall_left = 0; tag_seen = '0;
  endtask

  task automatic send_cmd(input int nad, input int npt);
    int b = 0;
    while (!cmd_ready_o && b < 3000) begin tick(1); b++; end
    check("cmd_ready_before_cmd", cmd_ready_o, 1);
    cur_n_ad = nad; cur_n_pt = npt;
    cmd_valid_i = 1; cmd_n_ad_i = CW'(nad); cmd_n_pt_i = CW'(npt);
    tick(1);
    cmd_valid_i = 0;
    check("start_one_cycle_after_accept", core_start_o, (npt != 0));
    if (npt == 0) check("err_on_zero_pt", err_o, 1);
  endtask

  task automatic wait_end(input int budget);
    int b = 0;
    while (done_cnt == 0 && err_cnt == 0 && b < budget) begin tick(1); b++; end
    check("session_end_within_bound", (b < budget), 1);
  endtask

  logic [63:0] vec[5];

  task automatic run_session(input int nad, input int npt, input bit given,
                             input int e_iss, input int e_out, input int e_done, input int e_err);
    logic [63:0] blk[$];
    logic [63:0] acc = '0;
    clear_sb();
    for (int i = 0; i < nad + npt; i++) begin
      if (given) blk.push_back(vec[i]);
      else blk.push_back({$urandom, $urandom});
      acc ^= blk[i];
    end
    foreach (blk[i]) feed_q.push_back(blk[i]);
    send_cmd(nad, npt);
    if (npt == 0) tick(15);
    else wait_end(3000);
    tick(3);
    check("issue_count", iss_d.size(), e_iss);
    check("out_count", out_d.size(), e_out);
    check("done_count", done_cnt, e_done);
    check("err_count", err_cnt, e_err);
    check("start_count", start_cnt, (npt != 0));
    check("ordering_violations", viol, 0);
    for (int i = 0; i < iss_d.size() && i < blk.size(); i++) begin
      check("issue_data", iss_d[i], blk[i]);
      check("issue_last", iss_l[i], (i == nad - 1) || (i == nad + npt - 1));
    end
    for (int j = 0; j < out_d.size() && j < npt; j++) begin
      check("out_data", out_d[j], blk[nad + j] ^ KEY);
      check("out_last", out_l[j], (j == npt - 1));
    end
    if (e_done != 0) check("tag", tag_seen, {acc, ~acc});
    if (npt == 0) check("cmd_ready_stays_high", cmd_ready_low, 0);
  endtask

  typedef struct {
    int n_ad; int n_pt; bit given; int e_iss; int e_out; int e_done; int e_err;
  } vec_t;
  vec_t tbl[4];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, still running required finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "global timeout");
  end

  initial begin
    int b;
    logic [63:0] nine[$];
    vec[0] = 64'h3230323380000000; vec[1] = 64'h436F6E636576657A;
    vec[2] = 64'h204153434F4E2065; vec[3] = 64'h6E2053797374656D;
    vec[4] = 64'h566572696C6F6780;
    tbl[0] = '{1, 4, 1'b1, 5, 4, 1, 0};
    tbl[1] = '{0, 2, 1'b0, 2, 2, 1, 0};
    tbl[2] = '{0, 0, 1'b0, 0, 0, 0, 1};
    tbl[3] = '{3, 2, 1'b0, 5, 2, 1, 0};
    cmd_valid_i = 0; cmd_n_ad_i = '0; cmd_n_pt_i = '0;
    rst = 1;
    tick(3);
    check("reset_ctrl", {cmd_ready_o, in_ready_o, busy_o, fifo_level_o, core_start_o,
                         core_data_valid_o, out_valid_o, done_o, err_o}, 12'b110_0000_00000);
    check("reset_tag", tag_o, 0);
    rst = 0;
    tick(2);

    foreach (tbl[k])
      run_session(tbl[k].n_ad, tbl[k].n_pt, tbl[k].given, tbl[k].e_iss,
                  tbl[k].e_out, tbl[k].e_done, tbl[k].e_err);

    // FIFO full with core stalled: ninth block waits for the first pop
    clear_sb();
    ready_allow = 0;
    for (int i = 0; i < 9; i++) nine.push_back({$urandom, $urandom});
    foreach (nine[i]) feed_q.push_back(nine[i]);
    send_cmd(4, 5);
    b = 0;
    while (fifo_level_o != 4'd8 && b < 60) begin tick(1); b++; end
    check("fifo_reaches_full", fifo_level_o, 8);
    check("in_ready_low_when_full", in_ready_o, 0);
    tick(5);
    check("ninth_block_held", feed_q.size(), 1);
    check("level_held_at_full", fifo_level_o, 8);
    ready_allow = 1;
    wait_end(3000);
    tick(3);
    check("full_issue_count", iss_d.size(), 9);
    for (int i = 0; i < iss_d.size() && i < 9; i++) check("full_order", iss_d[i], nine[i]);
    check("full_out_count", out_d.size(), 5);
    check("full_done", done_cnt, 1);

    // output stall of 20 cycles after the first ciphertext
    bp_mode = 2;
    run_session(0, 3, 1'b0, 3, 3, 1, 0);
    check("stall_happened", stall_started, 1);
    bp_mode = 0;

    // randomized sessions
    rand_ready = 1; rand_in = 1; bp_mode = 1;
    for (int r = 0; r < 6; r++) begin
      int na, np;
      na = $urandom_range(4);
      np = $urandom_range(5, 1);
      run_session(na, np, 1'b0, na + np, np, 1, 0);
    end
    rand_ready = 0; rand_in = 0; bp_mode = 0;

    // watchdog in TAG_WAIT with two surplus blocks left in the FIFO
    clear_sb();
    end_en = 0;
    for (int i = 0; i < 3; i++) feed_q.push_back({$urandom, $urandom});
    send_cmd(0, 1);
    b = 0;
    while (out_d.size() == 0 && b < 500) begin tick(1); b++; end
    tick(2);
    check("surplus_level", fifo_level_o, 2);
    b = 0;
    while (err_cnt == 0 && b < 1500) begin tick(1); b++; end
    check("timeout_err_seen", err_cnt, 1);
    check("timeout_latency", err_cyc - ov_rise_cyc, TO);
    check("timeout_flush", fifo_level_o, 0);
    check("timeout_idle", {busy_o, cmd_ready_o}, 2'b01);
    check("timeout_no_done", done_cnt, 0);
    end_en = 1;
    tick(3);

    // reset during PT
    clear_sb();
    for (int i = 0; i < 4; i++) feed_q.push_back({$urandom, $urandom});
    send_cmd(0, 4);
    b = 0;
    while (out_d.size() < 2 && b < 500) begin tick(1); b++; end
    check("pt_progress_before_reset", out_d.size(), 2);
    rst = 1;
    tick(1);
    rst = 0;
    check("midrst_ctrl", {cmd_ready_o, in_ready_o, busy_o, fifo_level_o, core_start_o,
                          core_data_valid_o, core_last_o, out_valid_o, out_last_o,
                          done_o, err_o}, 14'b110_0000_0000000);
    check("midrst_data", {core_data_o, out_data_o}, 0);
    check("midrst_tag", tag_o, 0);
    tick(40);
    check("midrst_no_done_err", done_cnt + err_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
